// File: rtl/spi_slave_frame_rx.sv
// SPI slave frame engine: pin synchronisers, CPOL/CPHA edge decode, rx/tx shifting,
// single-entry tx buffer. Optional LSB-first support is enabled by defining SPI_SLAVE_LSBFE_EN.
module spi_slave_frame_rx #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_STG = 2,
    parameter logic [DATA_W-1:0] IDLE_TX  = 8'hFF
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              ss_i,
    input  logic              sclk_i,
    input  logic              mosi_i,
    input  logic [1:0]        spi_mode_i,
    input  logic              spiswai_i,
`ifdef SPI_SLAVE_LSBFE_EN
    input  logic              lsbfe_i,
`endif
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_load_i,
    output logic              tx_empty_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              tip_o,
    output logic              miso_o,
    output logic              miso_oe_o,
    output logic              frame_err_o,
    output logic              tx_underrun_o
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [2:0] pin_vec;
    logic [2:0] pin_s;
    logic       ss_s, sclk_s, mosi_s;

    assign pin_vec = {ss_i, sclk_i, mosi_i};

    // Chains clear to 0 so a slave select already low at reset release never looks like a fall.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STG-1:0] chain_reg;
            always_ff @(posedge PCLK) begin
                if (PRESET) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STG-2:0], pin_vec[gi]};
                end
            end
            assign pin_s[gi] = chain_reg[SYNC_STG-1];
        end
    endgenerate

    assign ss_s   = pin_s[2];
    assign sclk_s = pin_s[1];
    assign mosi_s = pin_s[0];

    state_t            state_reg;
    logic              ss_prev_reg, sclk_prev_reg;
    logic              cpol_reg, cpha_reg, lsb_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-1:0] rx_shift_reg, tx_shift_reg, tx_buf_reg;
    logic              tx_empty_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic              rx_valid_reg, tip_reg, miso_reg, miso_oe_reg;
    logic              frame_err_reg, tx_underrun_reg;

    logic              lsb_start;
`ifdef SPI_SLAVE_LSBFE_EN
    assign lsb_start = lsbfe_i;
`else
    assign lsb_start = 1'b0;
`endif

    function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? (d >> 1) : (d << 1);
    endfunction

    logic              lead_edge, trail_edge, sample_edge, shift_edge;
    logic              ss_fall, ss_rise, last_bit;
    logic              start_frame, frame_done, consume;
    logic [DATA_W-1:0] tx_pick, rx_next;

    assign lead_edge   = (sclk_prev_reg == cpol_reg) && (sclk_s != cpol_reg);
    assign trail_edge  = (sclk_prev_reg != cpol_reg) && (sclk_s == cpol_reg);
    assign sample_edge = cpha_reg ? trail_edge : lead_edge;
    assign shift_edge  = cpha_reg ? lead_edge  : trail_edge;
    assign ss_fall     = ss_prev_reg && !ss_s;
    assign ss_rise     = !ss_prev_reg && ss_s;
    assign last_bit    = (bit_cnt_reg == CNT_W'(DATA_W - 1));

    assign start_frame = (state_reg == IDLE) && ss_fall && !spiswai_i;
    assign frame_done  = (state_reg == ACTIVE) && !ss_rise && sample_edge && last_bit;
    assign consume     = start_frame || frame_done;
    assign tx_pick     = tx_empty_reg ? IDLE_TX : tx_buf_reg;
    assign rx_next     = lsb_reg ? {mosi_s, rx_shift_reg[DATA_W-1:1]}
                                 : {rx_shift_reg[DATA_W-2:0], mosi_s};

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg       <= IDLE;
            ss_prev_reg     <= 1'b0;
            sclk_prev_reg   <= 1'b0;
            cpol_reg        <= 1'b0;
            cpha_reg        <= 1'b0;
            lsb_reg         <= 1'b0;
            bit_cnt_reg     <= '0;
            rx_shift_reg    <= '0;
            tx_shift_reg    <= '0;
            tx_buf_reg      <= '0;
            tx_empty_reg    <= 1'b1;
            rx_data_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            tip_reg         <= 1'b0;
            miso_reg        <= 1'b0;
            miso_oe_reg     <= 1'b0;
            frame_err_reg   <= 1'b0;
            tx_underrun_reg <= 1'b0;
        end else begin
            ss_prev_reg     <= ss_s;
            sclk_prev_reg   <= sclk_s;
            rx_valid_reg    <= 1'b0;
            frame_err_reg   <= 1'b0;
            tx_underrun_reg <= 1'b0;

            // A load coinciding with consumption refills the buffer after the old byte leaves.
            if (consume) begin
                tx_underrun_reg <= tx_empty_reg;
                tx_empty_reg    <= 1'b1;
            end
            if (tx_load_i) begin
                tx_buf_reg   <= tx_data_i;
                tx_empty_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (start_frame) begin
                        state_reg   <= ACTIVE;
                        cpol_reg    <= spi_mode_i[1];
                        cpha_reg    <= spi_mode_i[0];
                        lsb_reg     <= lsb_start;
                        bit_cnt_reg <= '0;
                        tip_reg     <= 1'b1;
                        miso_oe_reg <= 1'b1;
                        // CPHA=0 needs the first bit valid before the first sclk edge.
                        if (!spi_mode_i[0]) begin
                            miso_reg     <= first_bit(tx_pick, lsb_start);
                            tx_shift_reg <= advance(tx_pick, lsb_start);
                        end else begin
                            tx_shift_reg <= tx_pick;
                        end
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state_reg     <= IDLE;
                        tip_reg       <= 1'b0;
                        miso_oe_reg   <= 1'b0;
                        miso_reg      <= 1'b0;
                        bit_cnt_reg   <= '0;
                        frame_err_reg <= (bit_cnt_reg != '0);
                    end else begin
                        if (sample_edge) begin
                            rx_shift_reg <= rx_next;
                            if (last_bit) begin
                                bit_cnt_reg  <= '0;
                                rx_data_reg  <= rx_next;
                                rx_valid_reg <= 1'b1;
                                tx_shift_reg <= tx_pick;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            end
                        end
                        if (shift_edge) begin
                            miso_reg     <= first_bit(tx_shift_reg, lsb_reg);
                            tx_shift_reg <= advance(tx_shift_reg, lsb_reg);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign tx_empty_o    = tx_empty_reg;
    assign rx_data_o     = rx_data_reg;
    assign rx_valid_o    = rx_valid_reg;
    assign tip_o         = tip_reg;
    assign miso_o        = miso_reg;
    assign miso_oe_o     = miso_oe_reg;
    assign frame_err_o   = frame_err_reg;
    assign tx_underrun_o = tx_underrun_reg;

endmodule
